// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, full-scale default and the
// decoder state encoding used by pwm_duty_decoder and its consumers.
package pwm_pkg;

    localparam int DUTY_WIDTH = 11;
    localparam int PWM_MAX_VALUE_DEFAULT = 1200;

    typedef enum logic [2:0] {
        SEEK,
        HIGH,
        LOW,
        STUCK_HIGH,
        STUCK_LOW
    } pwm_dec_state_t;

    function automatic logic [DUTY_WIDTH-1:0] sat_duty(
        input int unsigned cnt,
        input int unsigned max_val
    );
        if (cnt > max_val)
            return DUTY_WIDTH'(max_val);
        return DUTY_WIDTH'(cnt);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an async input and produces registered level/rise/fall.
// Ports: clk, rst (sync, active-high), din in; lvl, rise, fall out.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;
    logic                   armed;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Strobes stay blanked until the synchronizer and the level flop
    // both hold real samples, so leaving reset never looks like an edge.
    assign armed = fill_q[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            lvl_q  <= sync_out;
            rise_q <= armed & sync_out & ~lvl_q;
            fall_q <= armed & ~sync_out & lvl_q;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures PWM high time and period, publishing once per period, with
// stuck-high/stuck-low detection.
// Ports: clk, rst (sync, active-high), pwm_in (async) in;
//        measured_duty, measured_period, sample_valid,
//        stuck_high, stuck_low out (all registered).
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int PWM_MAX_VALUE  = PWM_MAX_VALUE_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2400,
    parameter int SYNC_STAGES    = 2,
    parameter int PERIOD_WIDTH   = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwm_in,
    output logic [DUTY_WIDTH-1:0]   measured_duty,
    output logic [PERIOD_WIDTH-1:0] measured_period,
    output logic                    sample_valid,
    output logic                    stuck_high,
    output logic                    stuck_low
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [DUTY_WIDTH-1:0] FULL_DUTY =
        DUTY_WIDTH'(PWM_MAX_VALUE);

    logic lvl;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    pwm_dec_state_t   state;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;

    logic [PERIOD_WIDTH-1:0] period_sum;
    logic [DUTY_WIDTH-1:0]   duty_sat;

    // Both counts are bounded by TIMEOUT, so the sum fits by construction.
    assign period_sum = PERIOD_WIDTH'(high_cnt) + PERIOD_WIDTH'(low_cnt);
    assign duty_sat   = sat_duty(32'(high_cnt), PWM_MAX_VALUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SEEK;
            high_cnt        <= '0;
            low_cnt         <= '0;
            measured_duty   <= '0;
            measured_period <= '0;
            sample_valid    <= 1'b0;
            stuck_high      <= 1'b0;
            stuck_low       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                SEEK: begin
                    // First rise only starts a measurement; no publish.
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= ONE;
                    end else if (low_cnt >= TIMEOUT) begin
                        state           <= STUCK_LOW;
                        stuck_low       <= 1'b1;
                        measured_duty   <= '0;
                        measured_period <= '0;
                        sample_valid    <= 1'b1;
                    end else if (!lvl) begin
                        low_cnt <= low_cnt + ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= ONE;
                    end else if (high_cnt >= TIMEOUT) begin
                        state           <= STUCK_HIGH;
                        stuck_high      <= 1'b1;
                        measured_duty   <= FULL_DUTY;
                        measured_period <= '0;
                        sample_valid    <= 1'b1;
                    end else begin
                        high_cnt <= high_cnt + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state           <= HIGH;
                        high_cnt        <= ONE;
                        measured_duty   <= duty_sat;
                        measured_period <= period_sum;
                        sample_valid    <= 1'b1;
                    end else if (low_cnt >= TIMEOUT) begin
                        state           <= STUCK_LOW;
                        stuck_low       <= 1'b1;
                        measured_duty   <= '0;
                        measured_period <= '0;
                        sample_valid    <= 1'b1;
                    end else begin
                        low_cnt <= low_cnt + ONE;
                    end
                end
                STUCK_HIGH: begin
                    if (fall) begin
                        state      <= LOW;
                        low_cnt    <= ONE;
                        stuck_high <= 1'b0;
                    end
                end
                STUCK_LOW: begin
                    if (rise) begin
                        state     <= HIGH;
                        high_cnt  <= ONE;
                        stuck_low <= 1'b0;
                    end
                end
                default: begin
                    state <= SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: table-driven waveforms
// plus hand-written latency, stuck and reset sequences.
module tb_pwm_duty_decoder;

    localparam int TO   = 2400;
    localparam int PMAX = 1200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [10:0] measured_duty;
    logic [12:0] measured_period;
    logic        sample_valid;
    logic        stuck_high;
    logic        stuck_low;

    pwm_duty_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .pwm_in          (pwm_in),
        .measured_duty   (measured_duty),
        .measured_period (measured_period),
        .sample_valid    (sample_valid),
        .stuck_high      (stuck_high),
        .stuck_low       (stuck_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int period;
        bit sh;
        bit sl;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int n;
        int duty;
        int period;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && sample_valid) begin
            check("no_consecutive_valid", int'(prev_v), 0);
            check("valid_expected", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("duty", int'(measured_duty), e.duty);
                check("period", int'(measured_period), e.period);
                check("stuck_high_at_pub", int'(stuck_high), int'(e.sh));
                check("stuck_low_at_pub", int'(stuck_low), int'(e.sl));
            end
        end
        prev_v <= sample_valid & ~rst;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pwm_in = 1'b0;
        sbq.delete();
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_duty"}, int'(measured_duty), 0);
        check({tag, "_period"}, int'(measured_period), 0);
        check({tag, "_valid"}, int'(sample_valid), 0);
        check({tag, "_sh"}, int'(stuck_high), 0);
        check({tag, "_sl"}, int'(stuck_low), 0);
    endtask

    task automatic run_wave(input vec_t v);
        pwm_in = 1'b0;
        cyc(10);
        for (int i = 0; i < v.n; i++) begin
            pwm_in = 1'b1;
            if (i > 0)
                sbq.push_back('{v.duty, v.period, 1'b0, 1'b0});
            cyc(v.hi);
            pwm_in = 1'b0;
            cyc(v.lo);
        end
        pwm_in = 1'b1;
        sbq.push_back('{v.duty, v.period, 1'b0, 1'b0});
        cyc(20);
        pwm_in = 1'b0;
        cyc(10);
        check("drain", sbq.size(), 0);
        check("no_stuck_high", int'(stuck_high), 0);
        check("no_stuck_low", int'(stuck_low), 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{300, 900, 3, 300, 1200};
        vecs[1] = '{1500, 100, 3, PMAX, 1600};
        vecs[2] = '{1, 999, 3, 1, 1000};
        vecs[3] = '{600, 600, 2, 600, 1200};
        vecs[4] = '{1200, 1200, 2, 1200, 2400};
        vecs[5] = '{1201, 50, 2, PMAX, 1251};
        vecs[6] = '{2399, 2399, 2, PMAX, 4798};

        // Reset state
        do_reset();
        check_zero("reset");

        // Table-driven waveforms
        foreach (vecs[k]) begin
            do_reset();
            run_wave(vecs[k]);
        end

        // Latency: rise driven before edge t -> valid after edge t+3
        do_reset();
        pwm_in = 1'b0;
        cyc(10);
        pwm_in = 1'b1;
        cyc(100);
        pwm_in = 1'b0;
        cyc(100);
        pwm_in = 1'b1;
        sbq.push_back('{100, 200, 1'b0, 1'b0});
        cyc(3);
        check("lat_early", int'(sample_valid), 0);
        cyc(1);
        check("lat_hit", int'(sample_valid), 1);
        cyc(20);
        pwm_in = 1'b0;
        cyc(10);
        check("lat_drain", sbq.size(), 0);

        // Stuck high after a valid waveform
        do_reset();
        pwm_in = 1'b0;
        cyc(10);
        for (int i = 0; i < 2; i++) begin
            pwm_in = 1'b1;
            if (i > 0)
                sbq.push_back('{300, 1200, 1'b0, 1'b0});
            cyc(300);
            pwm_in = 1'b0;
            cyc(900);
        end
        pwm_in = 1'b1;
        sbq.push_back('{300, 1200, 1'b0, 1'b0});
        sbq.push_back('{PMAX, 0, 1'b1, 1'b0});
        cyc(TO + 3);
        check("sh_before", int'(stuck_high), 0);
        check("sh_valid_before", int'(sample_valid), 0);
        cyc(1);
        check("sh_set", int'(stuck_high), 1);
        check("sh_valid", int'(sample_valid), 1);
        cyc(600);
        check("sh_held", int'(stuck_high), 1);
        pwm_in = 1'b0;
        cyc(4);
        check("sh_cleared", int'(stuck_high), 0);
        cyc(20);
        check("sh_drain", sbq.size(), 0);

        // Stuck low from reset
        do_reset();
        sbq.push_back('{0, 0, 1'b0, 1'b1});
        cyc(TO);
        check("sl_before", int'(stuck_low), 0);
        cyc(1);
        check("sl_set", int'(stuck_low), 1);
        check("sl_valid", int'(sample_valid), 1);
        cyc(2600);
        check("sl_held", int'(stuck_low), 1);
        check("sl_drain", sbq.size(), 0);
        pwm_in = 1'b1;
        cyc(4);
        check("sl_cleared", int'(stuck_low), 0);
        cyc(20);
        pwm_in = 1'b0;
        cyc(10);
        check("sl_no_pub", sbq.size(), 0);

        // Reset in the middle of a high phase of 600/600
        do_reset();
        pwm_in = 1'b0;
        cyc(10);
        pwm_in = 1'b1;
        cyc(600);
        pwm_in = 1'b0;
        cyc(600);
        pwm_in = 1'b1;
        sbq.push_back('{600, 1200, 1'b0, 1'b0});
        cyc(200);
        check("mid_pre_drain", sbq.size(), 0);
        rst = 1'b1;
        cyc(1);
        check_zero("mid_rst");
        rst = 1'b0;
        cyc(399);
        pwm_in = 1'b0;
        cyc(600);
        pwm_in = 1'b1;
        cyc(600);
        pwm_in = 1'b0;
        cyc(600);
        pwm_in = 1'b1;
        sbq.push_back('{600, 1200, 1'b0, 1'b0});
        cyc(20);
        pwm_in = 1'b0;
        cyc(10);
        check("mid_drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
